// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline sequencing controller for the 5-stage MIPS core. Each cycle it
// decides whether PC and IF/ID advance and which pipeline registers get a
// bubble. It handles load-use stalls, control transfers resolved in MEM, and
// the halt opcode (6'b111111), which drains the pipe and freezes it.
//
// Optional feature macro: PIPE_PERF_CNT_EN builds the saturating stall and
// flush performance counters. When it is undefined, both outputs are tied to 0.
//
// Parameters:
//   DRAIN_CYCLES     bubble cycles after halt leaves ID before halted asserts
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   id_instr         instruction currently in ID
//   ex_memread       MemRead bit of the ID/EX control field
//   ex_rt            destination (rt) of the instruction in EX
//   mem_branch_taken MEM-stage branch resolved taken
//   mem_jump         jump bit of the EX/MEM control field
//   pc_we, ifid_we   PC / IF/ID load enables
//   ifid_flush       load NOP into IF/ID
//   idex_flush       zero the control field entering ID/EX
//   exmem_flush      zero the control field entering EX/MEM
//   halted           pipeline drained and frozen (state decode)
//   stall_cnt        RUN-state load-use stall cycles (saturating)
//   flush_cnt        applied redirect cycles (saturating)
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        mem_branch_taken,
  input  logic        mem_jump,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   drain_cnt, next_drain_cnt;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       use_rs, use_rt, is_halt, load_use, redirect;
  logic       unused_bits;

  assign opcode = id_instr[31:26];
  assign rs     = id_instr[25:21];
  assign rt     = id_instr[20:16];
  assign unused_bits = ^id_instr[15:0];

  assign is_halt = (opcode == 6'b111111);
  assign use_rs  = (opcode != 6'd2) && !is_halt;
  assign use_rt  = (opcode == 6'd0) || (opcode == 6'd4) ||
                   (opcode == 6'd5) || (opcode == 6'd43);

  // ex_rt != 0 also covers "register 0 never creates a hazard".
  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((use_rs && (rs == ex_rt)) || (use_rt && (rt == ex_rt)));
  assign redirect = mem_branch_taken || mem_jump;

  assign halted = (state == HALTED);

  // State and drain counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= {CW{1'b0}};
    end else begin
      state     <= next_state;
      drain_cnt <= next_drain_cnt;
    end
  end

  // Next-state and combinational control decode.
  always_comb begin
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    next_state     = state;
    next_drain_cnt = drain_cnt;
    case (state)
      RUN: begin
        if (redirect) begin
          // Anything in ID is wrong-path, including a halt or a hazard.
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (load_use) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
        end else if (is_halt) begin
          pc_we          = 1'b0;
          ifid_we        = 1'b0;
          idex_flush     = 1'b1;
          next_state     = DRAIN;
          next_drain_cnt = DRAIN_LOAD;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end
      DRAIN: begin
        if (redirect) begin
          // The halt was on a mispredicted path: redirect and resume.
          ifid_flush     = 1'b1;
          idex_flush     = 1'b1;
          exmem_flush    = 1'b1;
          next_state     = RUN;
          next_drain_cnt = {CW{1'b0}};
        end else begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          if (drain_cnt == {CW{1'b0}}) begin
            next_state = HALTED;
          end else begin
            next_drain_cnt = drain_cnt - {{(CW-1){1'b0}}, 1'b1};
          end
        end
      end
      HALTED: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
      default: begin
        pc_we          = 1'b0;
        ifid_we        = 1'b0;
        idex_flush     = 1'b1;
        next_state     = RUN;
        next_drain_cnt = {CW{1'b0}};
      end
    endcase
  end

`ifdef PIPE_PERF_CNT_EN
  logic        stall_ev, flush_ev;
  logic [15:0] stall_r, flush_r;

  // A stall only counts when it is actually applied (redirect has priority).
  assign stall_ev = (state == RUN) && !redirect && load_use;
  assign flush_ev = redirect && ((state == RUN) || (state == DRAIN));

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= 16'd0;
      flush_r <= 16'd0;
    end else begin
      if (stall_ev && (stall_r != 16'hFFFF)) begin
        stall_r <= stall_r + 16'd1;
      end
      if (flush_ev && (flush_r != 16'hFFFF)) begin
        flush_r <= flush_r + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_r;
  assign flush_cnt = flush_r;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DRAIN_CYCLES=3). Expected values are
// pushed to a scoreboard queue when stimulus is driven and popped on the
// following falling edge, where the DUT outputs are compared.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        mem_branch_taken;
  logic        mem_jump;
  logic        pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, halted}
  localparam logic [5:0] C_NORM  = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b000100;
  localparam logic [5:0] C_REDIR = 6'b111110;
  localparam logic [5:0] C_HALT  = 6'b000101;

  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam logic [31:0] I_ADD   = {6'd0, 5'd2, 5'd4, 5'd3, 11'h020};  // add $3,$2,$4
  localparam logic [31:0] I_ADD0  = {6'd0, 5'd0, 5'd0, 5'd1, 11'h020};  // add $1,$0,$0
  localparam logic [31:0] I_ADDI  = {6'd8, 5'd1, 5'd5, 16'd7};          // addi $5,$1,7
  localparam logic [31:0] I_SW    = {6'd43, 5'd1, 5'd5, 16'd0};         // sw $5,0($1)
  localparam logic [31:0] I_J     = {6'd2, 5'd5, 21'd0};                // j, rs bits = 5
  localparam logic [31:0] I_HALT  = {6'h3F, 26'd0};

  typedef struct packed {
    logic [5:0]  ctrl;
    logic [15:0] st;
    logic [15:0] fl;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_stall = 16'd0;
  logic [15:0] m_flush = 16'd0;

  task automatic push_exp(input logic [5:0] c);
    exp_t e;
    e.ctrl = c;
`ifdef PIPE_PERF_CNT_EN
    e.st = m_stall;
    e.fl = m_flush;
`else
    e.st = 16'd0;
    e.fl = 16'd0;
`endif
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t        e;
    logic [5:0]  obs;
    logic [31:0] obs_cnt;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=0 entries required=1", tag);
    end else begin
      e = sb.pop_front();
      obs = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, halted};
      obs_cnt = {stall_cnt, flush_cnt};
      checks++;
      assert (obs === e.ctrl) else begin
        failures++;
        $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, e.ctrl);
      end
      checks++;
      assert (obs_cnt === {e.st, e.fl}) else begin
        failures++;
        $error("FAIL %s counters observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
               tag, stall_cnt, flush_cnt, e.st, e.fl);
      end
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, then advance
  // the counter model at the rising edge.
  task automatic step(input string tag, input logic [31:0] instr, input logic mr,
                      input logic [4:0] rt, input logic bt, input logic jp,
                      input logic [5:0] ectrl, input logic cs, input logic cf);
    id_instr = instr;
    ex_memread = mr;
    ex_rt = rt;
    mem_branch_taken = bt;
    mem_jump = jp;
    push_exp(ectrl);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    if (cs && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
    if (cf && (m_flush != 16'hFFFF)) m_flush = m_flush + 16'd1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    id_instr = I_NOP;
    ex_memread = 1'b0;
    ex_rt = 5'd0;
    mem_branch_taken = 1'b0;
    mem_jump = 1'b0;

    push_exp(C_NORM);
    @(negedge clk);
    check("reset_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("idle",          I_NOP,  1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  1'b0, 1'b0);
    step("load_use",      I_ADD,  1'b1, 5'd2, 1'b0, 1'b0, C_STALL, 1'b1, 1'b0);
    step("after_bubble",  I_ADD,  1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  1'b0, 1'b0);
    step("rt_zero",       I_ADD0, 1'b1, 5'd0, 1'b0, 1'b0, C_NORM,  1'b0, 1'b0);
    step("addi_rt",       I_ADDI, 1'b1, 5'd5, 1'b0, 1'b0, C_NORM,  1'b0, 1'b0);
    step("sw_rt_use",     I_SW,   1'b1, 5'd5, 1'b0, 1'b0, C_STALL, 1'b1, 1'b0);
    step("j_no_rs",       I_J,    1'b1, 5'd5, 1'b0, 1'b0, C_NORM,  1'b0, 1'b0);
    step("redir_hazard",  I_ADD,  1'b1, 5'd2, 1'b1, 1'b0, C_REDIR, 1'b0, 1'b1);
    step("jump_redir",    I_ADD,  1'b0, 5'd0, 1'b0, 1'b1, C_REDIR, 1'b0, 1'b1);
    step("after_redir",   I_NOP,  1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  1'b0, 1'b0);

    // Halt: one RUN cycle, three DRAIN cycles, then frozen.
    step("halt_id",       I_HALT, 1'b0, 5'd0, 1'b0, 1'b0, C_STALL, 1'b0, 1'b0);
    step("drain1",        I_HALT, 1'b0, 5'd0, 1'b0, 1'b0, C_STALL, 1'b0, 1'b0);
    step("drain2",        I_HALT, 1'b0, 5'd0, 1'b0, 1'b0, C_STALL, 1'b0, 1'b0);
    step("drain3",        I_HALT, 1'b0, 5'd0, 1'b0, 1'b0, C_STALL, 1'b0, 1'b0);
    step("halted",        I_HALT, 1'b0, 5'd0, 1'b0, 1'b0, C_HALT,  1'b0, 1'b0);
    step("halt_ign_br",   I_NOP,  1'b0, 5'd0, 1'b1, 1'b0, C_HALT,  1'b0, 1'b0);
    step("halt_ign_j",    I_NOP,  1'b1, 5'd2, 1'b0, 1'b1, C_HALT,  1'b0, 1'b0);

    // Reset out of HALTED, then asynchronous reset in the middle of DRAIN.
    #2 rst_n = 1'b0;
    m_stall = 16'd0;
    m_flush = 16'd0;
    id_instr = I_NOP;
    mem_branch_taken = 1'b0;
    mem_jump = 1'b0;
    ex_memread = 1'b0;
    #1 push_exp(C_NORM);
    check("reset_from_halted");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("redir_cnt",     I_NOP,  1'b0, 5'd0, 1'b1, 1'b0, C_REDIR, 1'b0, 1'b1);
    step("stall_cnt",     I_ADD,  1'b1, 5'd4, 1'b0, 1'b0, C_STALL, 1'b1, 1'b0);
    step("halt_id2",      I_HALT, 1'b0, 5'd0, 1'b0, 1'b0, C_STALL, 1'b0, 1'b0);
    step("drain1b",       I_HALT, 1'b0, 5'd0, 1'b0, 1'b0, C_STALL, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    m_stall = 16'd0;
    m_flush = 16'd0;
    id_instr = I_NOP;
    #1 push_exp(C_NORM);
    check("reset_mid_drain");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("run_after_rst", I_NOP,  1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  1'b0, 1'b0);

    // Speculative halt: jump resolves in the second DRAIN cycle.
    step("spec_halt",     I_HALT, 1'b0, 5'd0, 1'b0, 1'b0, C_STALL, 1'b0, 1'b0);
    step("spec_drain1",   I_NOP,  1'b0, 5'd0, 1'b0, 1'b0, C_STALL, 1'b0, 1'b0);
    step("spec_drain2_j", I_NOP,  1'b0, 5'd0, 1'b0, 1'b1, C_REDIR, 1'b0, 1'b1);
    step("spec_run1",     I_NOP,  1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  1'b0, 1'b0);
    step("spec_run2",     I_ADD,  1'b1, 5'd2, 1'b0, 1'b0, C_STALL, 1'b1, 1'b0);
    step("spec_run3",     I_NOP,  1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  1'b0, 1'b0);
    step("spec_run4",     I_NOP,  1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  1'b0, 1'b0);
    step("spec_run5",     I_NOP,  1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  1'b0, 1'b0);

    // Halt in ID together with a redirect is wrong-path: stays in RUN.
    step("halt_redir",    I_HALT, 1'b0, 5'd0, 1'b1, 1'b0, C_REDIR, 1'b0, 1'b1);
    step("halt_redir_run",I_NOP,  1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Each cycle it decides whether the PC and IF/ID register advance, and which pipeline registers are loaded with a bubble. It covers load-use stalls, control transfers resolved in MEM (Branch/jump from the MEM control field), and the `halt` opcode (6'b111111), which drains the pipe and freezes it. It sits beside the control decoder in ID and drives the write-enable and flush pins of the PC and the IF/ID, ID/EX and EX/MEM registers.

## Interface
- `DRAIN_CYCLES`, default 3: bubble cycles after `halt` leaves ID before `halted` asserts. Covers EX, MEM and WB.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_instr`  in  32  instruction currently in ID.
- `ex_memread`  in  1  MemRead bit of the ID/EX control field.
- `ex_rt`  in  5  destination (rt) of the instruction in EX.
- `mem_branch_taken`  in  1  MEM-stage branch resolved taken.
- `mem_jump`  in  1  jump bit of the EX/MEM control field.
- `pc_we`  out  1  PC load enable.
- `ifid_we`  out  1  IF/ID load enable.
- `ifid_flush`  out  1  load NOP into IF/ID.
- `idex_flush`  out  1  zero the 13-bit control field entering ID/EX.
- `exmem_flush`  out  1  zero the control field entering EX/MEM.
- `halted`  out  1  pipeline drained and frozen.
- `stall_cnt`, `flush_cnt`  out  16 each  performance counters (see Configuration).

## Operation
- FSM states: RUN, DRAIN, HALTED. Registered: 2-bit state, a drain counter of width clog2(DRAIN_CYCLES+1), and the perf counters.
- Source decode of `id_instr`:
  - rs is used by every opcode except j (6'd2) and halt.
  - rt is used by R-type (0), beq (4), bne (5) and sw (43).
  - Register 0 never creates a hazard.
- `load_use` = `ex_memread` AND `ex_rt`≠0 AND `ex_rt` matches a used source.
- `redirect` = `mem_branch_taken` OR `mem_jump`.
- Priority in RUN, highest first:
  1. redirect: `ifid_flush`=`idex_flush`=`exmem_flush`=1, `pc_we`=1, `ifid_we`=1. Any hazard or halt in ID is wrong-path and is discarded.
  2. load_use: `pc_we`=0, `ifid_we`=0, `idex_flush`=1. Lasts exactly one cycle, because the bubble clears ex_memread.
  3. ID opcode is halt: `pc_we`=0, `ifid_we`=0, `idex_flush`=1. Next state DRAIN, counter loaded with DRAIN_CYCLES-1.
  4. otherwise: `pc_we`=`ifid_we`=1, all flushes 0.
- DRAIN:
  - `pc_we`=`ifid_we`=0, `idex_flush`=1; the counter decrements each cycle.
  - Leaves for HALTED when the counter reaches 0.
  - A redirect in DRAIN means the halt was speculative. Apply the redirect outputs and return to RUN.
- HALTED:
  - `halted`=1, `pc_we`=`ifid_we`=0, `idex_flush`=1.
  - Only `rst_n` exits HALTED; redirect is ignored.

## Timing
- All control outputs are combinational from state and inputs, so they take effect at the same clock edge that would otherwise advance the pipe. Zero latency.
- `halted` is a registered state decode. It asserts DRAIN_CYCLES+1 edges after halt is first seen in ID with no redirect: 1 edge to enter DRAIN, then DRAIN_CYCLES edges to reach HALTED.
- Reset (asynchronous, any time, including mid-DRAIN):
  - state=RUN, counter=0, `halted`=0, `stall_cnt`=`flush_cnt`=0.
  - While reset is held, the outputs follow RUN decode. With idle inputs that gives `pc_we`=`ifid_we`=1 and flushes 0.
- Simultaneous load_use and redirect: redirect wins, and the stall is not counted.
- Counters saturate at 16'hFFFF; they do not wrap.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every RUN-state load_use stall cycle.
  - `flush_cnt` increments on every redirect cycle.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Load-use: lw $2 in EX (`ex_memread`=1, `ex_rt`=2) with add $3,$2,$4 in ID -> one cycle of `pc_we`=0, `ifid_we`=0, `idex_flush`=1, then normal advance; `stall_cnt`=1.
- $0 and unused-rt cases:
  - `ex_rt`=0 with rs=0 -> no stall.
  - addi with rt=`ex_rt`=5 -> no stall, because addi does not use rt as a source.
- Redirect overrides a hazard: `mem_branch_taken`=1 together with a load-use condition -> all three flushes=1, `pc_we`=1; `stall_cnt` unchanged, `flush_cnt`+1.
- Halt with DRAIN_CYCLES=3: halt held in ID -> DRAIN for 3 cycles, then `halted`=1 on the 4th edge; later redirects are ignored.
- Speculative halt: halt in ID, then `mem_jump`=1 in the 2nd DRAIN cycle -> flushes asserted, state RUN, `halted` never asserts.
- Reset mid-DRAIN: drop `rst_n` asynchronously -> state RUN and counters 0 immediately, without waiting for a clock edge.
